// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int N_BITS    = 32;
  localparam int M_WORDS   = 16;
  localparam int BLK_BYTES = 64;
  localparam int LEN_POS   = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [N_BITS-1:0] word_t;

  // FILL : accepting message bytes into the block buffer
  // PAD  : writing 0x80 / zero fill, one byte per cycle
  // LEN  : writing the 64-bit bit length into bytes 56..63
  // OUT  : holding a complete block until the core takes it
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    OUT  = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sha256_msg_pad_if.sv
// Byte-stream input and block output bundle between the message source,
// the padder and the hash core.
interface sha256_msg_pad_if;
  import sha256_pkg::*;

  logic                 din_valid_i;
  logic [7:0]           din_i;
  logic                 din_keep_i;
  logic                 din_last_i;
  logic                 din_ready_o;

  word_t [M_WORDS-1:0]  blk_o;
  logic                 blk_valid_o;
  logic                 blk_ready_i;
  logic                 blk_first_o;
  logic                 blk_last_o;

  // Padder view: consumes bytes, produces blocks.
  modport master (
    input  din_valid_i, din_i, din_keep_i, din_last_i, blk_ready_i,
    output din_ready_o, blk_o, blk_valid_o, blk_first_o, blk_last_o
  );

  // Environment view: produces bytes, consumes blocks.
  modport slave (
    output din_valid_i, din_i, din_keep_i, din_last_i, blk_ready_i,
    input  din_ready_o, blk_o, blk_valid_o, blk_first_o, blk_last_o
  );

endinterface

// File: rtl/sha256_msg_pad_blk_buf.sv
// 64-byte block buffer: single byte write port, an 8-byte big-endian length
// write at LEN_POS, and a 16-word big-endian read view.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [5:0]          idx_i,
  input  logic [7:0]          data_i,
  input  logic                len_we_i,
  input  logic [63:0]         len_i,
  output word_t [M_WORDS-1:0] blk_o
);

  logic [7:0] mem_q [BLK_BYTES];
  logic [7:0] mem_d [BLK_BYTES];

  // Next buffer contents: byte write and length write are never concurrent.
  always_comb begin
    for (int i = 0; i < BLK_BYTES; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[idx_i] = data_i;
    end
    if (len_we_i) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[LEN_POS+i] = len_i[63-8*i -: 8];
      end
    end
  end

  // Buffer registers; cleared on reset so the block output reads zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Word w carries bytes 4w..4w+3, lowest byte index in the top bits.
  always_comb begin
    for (int w = 0; w < M_WORDS; w++) begin
      blk_o[w] = {mem_q[4*w], mem_q[4*w+1], mem_q[4*w+2], mem_q[4*w+3]};
    end
  end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: collects message bytes, appends 0x80, zero fill
// and the 64-bit bit length, and hands out 512-bit blocks flagged first/last.
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sha256_msg_pad_if.master bus
);

  pad_state_t        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              lastblk_q, lastblk_d;
  logic              padmode_q, padmode_d;
  logic              pad_first_q, pad_first_d;

  logic              buf_we;
  logic [7:0]        buf_data;
  logic              buf_len_we;
  logic [63:0]       len_bits;
  word_t [M_WORDS-1:0] blk_view;

  logic              beat_acc;
  logic              blk_acc;

  assign beat_acc = bus.din_valid_i && (state_q == FILL);
  assign blk_acc  = bus.blk_ready_i && (state_q == OUT);
  assign len_bits = 64'({cnt_q, 3'b000});

  // FSM next state, counters, flags and buffer write controls.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    lastblk_d   = lastblk_q;
    padmode_d   = padmode_q;
    pad_first_d = pad_first_q;
    buf_we      = 1'b0;
    buf_data    = bus.din_i;
    buf_len_we  = 1'b0;

    case (state_q)
      FILL: begin
        if (beat_acc) begin
          if (bus.din_keep_i) begin
            buf_we = 1'b1;
            idx_d  = idx_q + 6'd1;
            cnt_d  = cnt_q + LEN_W'(1);
          end
          if (bus.din_last_i) begin
            pad_first_d = 1'b1;
            // A last byte that completes the buffer must ship the full
            // block before the 0x80 can start the next one.
            if (bus.din_keep_i && idx_q == 6'd63) begin
              state_d   = OUT;
              lastblk_d = 1'b0;
              padmode_d = 1'b1;
            end else begin
              state_d = PAD;
            end
          end else if (bus.din_keep_i && idx_q == 6'd63) begin
            state_d   = OUT;
            lastblk_d = 1'b0;
            padmode_d = 1'b0;
          end
        end
      end

      PAD: begin
        buf_we      = 1'b1;
        buf_data    = pad_first_q ? PAD_BYTE : 8'h00;
        pad_first_d = 1'b0;
        idx_d       = idx_q + 6'd1;
        if (idx_q == 6'(LEN_POS-1)) begin
          state_d = LEN;
        end else if (idx_q == 6'd63) begin
          // No room for the length in this block: emit it and continue
          // padding into an extra block.
          state_d   = OUT;
          lastblk_d = 1'b0;
          padmode_d = 1'b1;
        end
      end

      LEN: begin
        buf_len_we = 1'b1;
        state_d    = OUT;
        lastblk_d  = 1'b1;
      end

      OUT: begin
        if (blk_acc) begin
          first_d = lastblk_q;
          idx_d   = 6'd0;
          if (lastblk_q) begin
            state_d   = FILL;
            cnt_d     = '0;
            padmode_d = 1'b0;
          end else if (padmode_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // State, counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= FILL;
      idx_q       <= 6'd0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      lastblk_q   <= 1'b0;
      padmode_q   <= 1'b0;
      pad_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      lastblk_q   <= lastblk_d;
      padmode_q   <= padmode_d;
      pad_first_q <= pad_first_d;
    end
  end

  sha256_blk_buf u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (buf_we),
    .idx_i    (idx_q),
    .data_i   (buf_data),
    .len_we_i (buf_len_we),
    .len_i    (len_bits),
    .blk_o    (blk_view)
  );

  // Output drive; flags only asserted while a block is presented.
  always_comb begin
    bus.din_ready_o = (state_q == FILL);
    bus.blk_valid_o = (state_q == OUT);
    bus.blk_first_o = (state_q == OUT) && first_q;
    bus.blk_last_o  = (state_q == OUT) && lastblk_q;
    bus.blk_o       = blk_view;
  end

endmodule
